// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between the I-cache and D-cache.
// One outstanding memory transaction; each cache keeps its request/ready/ack handshake.
module mem_arbiter #(
    parameter int ADDR_W = 20,
    parameter int LINE_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reqI,
    input  logic [ADDR_W-1:0] reqAddrI,
    output logic              read_ready_I,
    output logic [LINE_W-1:0] data_to_I,
    input  logic              reqD,
    input  logic              reqD_we,
    input  logic [ADDR_W-1:0] reqAddrD,
    input  logic [LINE_W-1:0] wdataD,
    output logic              read_ready_D,
    output logic              written_ack_D,
    output logic [LINE_W-1:0] data_to_D,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  grantsI,
    output logic [CNT_W-1:0]  grantsD
);

    typedef enum logic [1:0] {IDLE, MEM_I, MEM_D, RESP} state_t;

    state_t              state_reg, state_next;
    logic                last_d_reg;   // 1 when the most recent grant went to D
    logic                owner_d_reg;  // owner of the transaction in flight
    logic                we_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [LINE_W-1:0]   wdata_reg;
    logic [LINE_W-1:0]   data_i_reg;
    logic [LINE_W-1:0]   data_d_reg;
    logic [CNT_W-1:0]    grants_i_reg;
    logic [CNT_W-1:0]    grants_d_reg;
    logic                grant_i;
    logic                grant_d;

    // Grant decision is combinational on the live request levels in IDLE.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state_reg == IDLE) begin
            if (reqI && reqD) begin
                if (last_d_reg) grant_i = 1'b1;
                else            grant_d = 1'b1;
            end else if (reqI) begin
                grant_i = 1'b1;
            end else if (reqD) begin
                grant_d = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (grant_i)      state_next = MEM_I;
                else if (grant_d) state_next = MEM_D;
            end
            MEM_I, MEM_D: begin
                if (mem_ready) state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mem_req       = 1'b0;
        busy          = 1'b0;
        read_ready_I  = 1'b0;
        read_ready_D  = 1'b0;
        written_ack_D = 1'b0;
        unique case (state_reg)
            IDLE: ;
            MEM_I, MEM_D: begin
                mem_req = 1'b1;
                busy    = 1'b1;
            end
            RESP: begin
                busy          = 1'b1;
                read_ready_I  = !owner_d_reg;
                read_ready_D  = owner_d_reg && !we_reg;
                written_ack_D = owner_d_reg && we_reg;
            end
            default: ;
        endcase
    end

    // Transaction latches: frozen from grant until the next grant, so the
    // memory side never sees the requester's inputs change mid-transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_d_reg  <= 1'b0;
            owner_d_reg <= 1'b0;
            we_reg      <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
        end else if (grant_i) begin
            last_d_reg  <= 1'b0;
            owner_d_reg <= 1'b0;
            we_reg      <= 1'b0;
            addr_reg    <= reqAddrI;
            wdata_reg   <= '0;
        end else if (grant_d) begin
            last_d_reg  <= 1'b1;
            owner_d_reg <= 1'b1;
            we_reg      <= reqD_we;
            addr_reg    <= reqAddrD;
            wdata_reg   <= wdataD;
        end
    end

    // Read data capture; mem_ready outside a memory state is ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_i_reg <= '0;
            data_d_reg <= '0;
        end else if (mem_ready) begin
            if (state_reg == MEM_I)
                data_i_reg <= mem_rdata;
            else if (state_reg == MEM_D && !we_reg)
                data_d_reg <= mem_rdata;
        end
    end

    // Completed-transaction counters, wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grants_i_reg <= '0;
            grants_d_reg <= '0;
        end else if (state_reg == RESP) begin
            if (owner_d_reg) grants_d_reg <= grants_d_reg + 1'b1;
            else             grants_i_reg <= grants_i_reg + 1'b1;
        end
    end

    assign mem_we    = we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign data_to_I = data_i_reg;
    assign data_to_D = data_d_reg;
    assign grantsI   = grants_i_reg;
    assign grantsD   = grants_d_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter with a hand-driven memory responder.
module tb_mem_arbiter;

    localparam int ADDR_W = 20;
    localparam int LINE_W = 128;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              reqI;
    logic [ADDR_W-1:0] reqAddrI;
    logic              read_ready_I;
    logic [LINE_W-1:0] data_to_I;
    logic              reqD;
    logic              reqD_we;
    logic [ADDR_W-1:0] reqAddrD;
    logic [LINE_W-1:0] wdataD;
    logic              read_ready_D;
    logic              written_ack_D;
    logic [LINE_W-1:0] data_to_D;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              busy;
    logic [CNT_W-1:0]  grantsI;
    logic [CNT_W-1:0]  grantsD;

    int passed = 0;
    int total  = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .reqI(reqI), .reqAddrI(reqAddrI), .read_ready_I(read_ready_I), .data_to_I(data_to_I),
        .reqD(reqD), .reqD_we(reqD_we), .reqAddrD(reqAddrD), .wdataD(wdataD),
        .read_ready_D(read_ready_D), .written_ack_D(written_ack_D), .data_to_D(data_to_D),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy), .grantsI(grantsI), .grantsD(grantsD)
    );

    always #5 clk = ~clk;

    // kind: 1 = I read, 2 = D read, 3 = D write
    typedef struct {
        logic              r_i;
        logic [ADDR_W-1:0] a_i;
        logic              r_d;
        logic              we_d;
        logic [ADDR_W-1:0] a_d;
        logic [LINE_W-1:0] wd;
        logic [LINE_W-1:0] rd;
        int                mwait;
        int                exp_kind;
        logic [ADDR_W-1:0] exp_addr;
        logic              exp_we;
        logic [LINE_W-1:0] exp_di;
        logic [LINE_W-1:0] exp_dd;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passed++;
    endtask

    // Waits (bounded) for mem_req, holds it mwait cycles, pulses mem_ready,
    // then reports which response pulse appeared one cycle later.
    task automatic serve_one(input logic [LINE_W-1:0] rd, input int mwait,
                             input logic do_alt, input logic [ADDR_W-1:0] alt_a,
                             output int kind, output int lat,
                             output logic [ADDR_W-1:0] a, output logic w,
                             output logic [LINE_W-1:0] wd, output logic stable);
        int npulse;
        kind = 0; lat = 0; stable = 1'b1; a = '0; w = 1'b0; wd = '0;
        while (!mem_req && lat < 20) begin
            tick();
            lat++;
        end
        if (!mem_req) begin
            check("mem_req_timeout", 128'(mem_req), 128'd1);
            return;
        end
        a = mem_addr; w = mem_we; wd = mem_wdata;
        if (do_alt) reqAddrI = alt_a;
        for (int k = 0; k < mwait; k++) begin
            tick();
            if (mem_addr !== a || mem_we !== w || mem_wdata !== wd || mem_req !== 1'b1)
                stable = 1'b0;
        end
        mem_ready = 1'b1;
        mem_rdata = rd;
        tick();
        mem_ready = 1'b0;
        mem_rdata = '0;
        npulse = int'(read_ready_I) + int'(read_ready_D) + int'(written_ack_D);
        if (npulse != 1)      kind = 10 + npulse;
        else if (read_ready_I) kind = 1;
        else if (read_ready_D) kind = 2;
        else                   kind = 3;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        reqI = 1'b0; reqAddrI = '0; reqD = 1'b0; reqD_we = 1'b0;
        reqAddrD = '0; wdataD = '0; mem_rdata = '0; mem_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    vec_t              vecs[4];
    int                kind, lat;
    logic [ADDR_W-1:0] a;
    logic              w;
    logic [LINE_W-1:0] wd;
    logic              stable;
    int                exp_gi, exp_gd;
    int                order[6];
    logic [LINE_W-1:0] d_line, f_line, x_line, five_line;

    initial begin
        d_line    = 128'hDEADBEEF_DEADBEEF_DEADBEEF_00000001;
        f_line    = {LINE_W{1'b1}};
        x_line    = {16{8'hA5}};
        five_line = {16{8'h55}};

        vecs[0] = '{1'b1, 20'h00400, 1'b0, 1'b0, 20'h0,     '0,        d_line, 3, 1, 20'h00400, 1'b0, d_line, '0};
        vecs[1] = '{1'b0, 20'h0,     1'b1, 1'b0, 20'h01000, '0,        x_line, 1, 2, 20'h01000, 1'b0, d_line, x_line};
        vecs[2] = '{1'b0, 20'h0,     1'b1, 1'b1, 20'h00020, five_line, f_line, 2, 3, 20'h00020, 1'b1, d_line, x_line};
        vecs[3] = '{1'b1, 20'hFFFFF, 1'b0, 1'b0, 20'h0,     '0,        f_line, 0, 1, 20'hFFFFF, 1'b0, f_line, x_line};

        // Reset values, sampled while reset is still asserted.
        reset = 1'b0;
        reqI = 1'b0; reqAddrI = '0; reqD = 1'b0; reqD_we = 1'b0;
        reqAddrD = '0; wdataD = '0; mem_rdata = '0; mem_ready = 1'b0;
        tick();
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_mem_req", 128'(mem_req), 128'd0);
        check("rst_pulses", 128'({read_ready_I, read_ready_D, written_ack_D}), 128'd0);
        check("rst_data_I", data_to_I, '0);
        check("rst_data_D", data_to_D, '0);
        check("rst_grants", 128'({grantsI, grantsD}), 128'd0);
        do_reset();

        // Single-requester transactions from the table.
        exp_gi = 0; exp_gd = 0;
        for (int i = 0; i < 4; i++) begin
            reqI = vecs[i].r_i; reqAddrI = vecs[i].a_i;
            reqD = vecs[i].r_d; reqD_we = vecs[i].we_d;
            reqAddrD = vecs[i].a_d; wdataD = vecs[i].wd;
            serve_one(vecs[i].rd, vecs[i].mwait, 1'b0, '0, kind, lat, a, w, wd, stable);
            if (vecs[i].exp_kind == 1) exp_gi++; else exp_gd++;
            $display("vec %0d: kind=%0d lat=%0d addr=%h we=%0d", i, kind, lat, a, w);
            check($sformatf("v%0d_kind", i), 128'(kind), 128'(vecs[i].exp_kind));
            check($sformatf("v%0d_req_lat", i), 128'(lat), 128'd1);
            check($sformatf("v%0d_addr", i), 128'(a), 128'(vecs[i].exp_addr));
            check($sformatf("v%0d_we", i), 128'(w), 128'(vecs[i].exp_we));
            if (vecs[i].exp_we) check($sformatf("v%0d_wdata", i), wd, vecs[i].wd);
            check($sformatf("v%0d_stable", i), 128'(stable), 128'd1);
            check($sformatf("v%0d_req_drop", i), 128'(mem_req), 128'd0);
            check($sformatf("v%0d_data_I", i), data_to_I, vecs[i].exp_di);
            check($sformatf("v%0d_data_D", i), data_to_D, vecs[i].exp_dd);
            reqI = 1'b0; reqD = 1'b0; reqD_we = 1'b0;
            tick();
            check($sformatf("v%0d_grantsI", i), 128'(grantsI), 128'(exp_gi));
            check($sformatf("v%0d_grantsD", i), 128'(grantsD), 128'(exp_gd));
            check($sformatf("v%0d_busy", i), 128'(busy), 128'd0);
        end

        // Simultaneous requests after reset: D first, then I, and nothing more.
        do_reset();
        reqI = 1'b1; reqAddrI = 20'h00400;
        reqD = 1'b1; reqD_we = 1'b0; reqAddrD = 20'h01000;
        serve_one(x_line, 1, 1'b0, '0, kind, lat, a, w, wd, stable);
        $display("conflict 1st: kind=%0d addr=%h", kind, a);
        check("conf_first", 128'(kind), 128'd2);
        reqD = 1'b0;
        serve_one(d_line, 1, 1'b0, '0, kind, lat, a, w, wd, stable);
        $display("conflict 2nd: kind=%0d addr=%h", kind, a);
        check("conf_second", 128'(kind), 128'd1);
        check("conf_second_addr", 128'(a), 128'h00400);
        reqI = 1'b0;
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (mem_req || read_ready_I || read_ready_D || written_ack_D) stable = 1'b0;
        end
        check("conf_no_extra", 128'(stable), 128'd1);

        // Both held high: grants alternate starting with D.
        do_reset();
        reqI = 1'b1; reqAddrI = 20'h00400;
        reqD = 1'b1; reqD_we = 1'b0; reqAddrD = 20'h01000;
        for (int t = 0; t < 6; t++) begin
            serve_one(d_line, 1, 1'b0, '0, kind, lat, a, w, wd, stable);
            order[t] = kind;
            $display("rr txn %0d: kind=%0d", t, kind);
            check($sformatf("rr_%0d", t), 128'(kind), (t % 2 == 0) ? 128'd2 : 128'd1);
        end
        reqI = 1'b0; reqD = 1'b0;
        tick();
        check("rr_grantsI", 128'(grantsI), 128'd3);
        check("rr_grantsD", 128'(grantsD), 128'd3);

        // Reset in MEM_D, late mem_ready after release must be ignored.
        do_reset();
        reqD = 1'b1; reqD_we = 1'b0; reqAddrD = 20'h01000;
        tick();
        tick();
        check("abort_in_mem", 128'({busy, mem_req}), 128'b11);
        reset = 1'b0;
        #1;
        check("abort_busy_async", 128'(busy), 128'd0);
        tick();
        reset = 1'b1;
        reqD = 1'b0;
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            mem_ready = (k == 1);
            mem_rdata = (k == 1) ? f_line : '0;
            tick();
            if (read_ready_I || read_ready_D || written_ack_D || busy) stable = 1'b0;
        end
        mem_ready = 1'b0;
        mem_rdata = '0;
        $display("abort: busy=%0d grantsI=%0d grantsD=%0d", busy, grantsI, grantsD);
        check("abort_quiet", 128'(stable), 128'd1);
        check("abort_counters", 128'({grantsI, grantsD}), 128'd0);
        check("abort_data_D", data_to_D, '0);
        reqI = 1'b1; reqAddrI = 20'h00400;
        serve_one(d_line, 2, 1'b0, '0, kind, lat, a, w, wd, stable);
        $display("after abort: kind=%0d addr=%h", kind, a);
        check("abort_next_kind", 128'(kind), 128'd1);
        reqI = 1'b0;
        tick();
        check("abort_next_grantsI", 128'(grantsI), 128'd1);

        // Requester changes its address mid-transaction.
        reqI = 1'b1; reqAddrI = 20'h00400;
        serve_one(f_line, 3, 1'b1, 20'h00800, kind, lat, a, w, wd, stable);
        $display("addr change: kind=%0d addr=%h stable=%0d", kind, a, stable);
        check("alt_addr", 128'(a), 128'h00400);
        check("alt_stable", 128'(stable), 128'd1);
        check("alt_kind", 128'(kind), 128'd1);
        reqI = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
